// File: rtl/float_to_fixed_stream.sv
// float_to_fixed_stream: 4-stage float to signed fixed-point converter with valid/ready backpressure
// Ports: clk, resetn (async active-low); s_valid/s_ready/s_data/s_round input stream;
//        m_valid/m_ready/m_data output stream with m_overflow, m_inexact, m_invalid flags.
module float_to_fixed_stream #(
    parameter int MANTISSA_SIZE = 23,
    parameter int EXPONENT_SIZE = 8,
    parameter int INT_SIZE      = 32,
    parameter int FRAC_BITS     = 0,
    parameter int SATURATE      = 1
) (
    input  logic                                   clk,
    input  logic                                   resetn,
    input  logic                                   s_valid,
    output logic                                   s_ready,
    input  logic [EXPONENT_SIZE+MANTISSA_SIZE:0]   s_data,
    input  logic [1:0]                             s_round,
    output logic                                   m_valid,
    input  logic                                   m_ready,
    output logic [INT_SIZE-1:0]                    m_data,
    output logic                                   m_overflow,
    output logic                                   m_inexact,
    output logic                                   m_invalid
);
    localparam int M    = MANTISSA_SIZE;
    localparam int E    = EXPONENT_SIZE;
    localparam int W    = INT_SIZE;
    localparam int BIAS = 2 ** (E - 1) - 1;
    localparam int LW   = M + W + 2;
    localparam int SW   = $clog2(W + 2) + 1;
    localparam logic [W+1:0] POS_LIM = {3'b000, {(W-1){1'b1}}};
    localparam logic [W+1:0] NEG_LIM = {3'b001, {(W-1){1'b0}}};
    localparam logic [W-1:0] MAX_V   = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] MIN_V   = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0] ZERO_V  = '0;
    logic en;
    logic [E-1:0] exp_f;
    logic [M-1:0] man_f;
    logic signed [31:0] e_c, la_c, ra_c;
    logic left_c;
    logic [SW-1:0] sh_c;
    logic v1, sgn1, zero1, inf1, nan1, left1;
    logic [SW-1:0] sh1;
    logic [M:0] sig1;
    logic [1:0] rnd1;
    logic [LW-1:0] lwide;
    logic [2*M+2:0] rwide;
    logic [W:0] mag_c;
    logic hi_c, g_c, st_c;
    logic v2, sgn2, zero2, inf2, nan2, hi2, g2, s2;
    logic [W:0] mag2;
    logic [1:0] rnd2;
    logic inc_c, ovf_c, inx_c;
    logic [W+1:0] sum_c;
    logic v3, sgn3, ovf3, inx3, nan3;
    logic [W-1:0] mag3;
    logic [W-1:0] data_c;
    assign en      = ~m_valid | m_ready;
    assign s_ready = en;
    // Unpack: the shift amount is clamped so huge or very negative exponents never wrap.
    always_comb begin
        exp_f  = s_data[M+E-1:M];
        man_f  = s_data[M-1:0];
        e_c    = $signed(32'(exp_f)) - BIAS + FRAC_BITS;
        la_c   = e_c - M;
        ra_c   = M - e_c;
        left_c = e_c >= M;
        sh_c   = left_c ? (la_c > W + 1 ? SW'(W + 1) : SW'(la_c))
                        : (ra_c > M + 2 ? SW'(M + 2) : SW'(ra_c));
    end
    // Shift: right shifts keep two extra positions below the kept LSB for guard and sticky.
    always_comb begin
        lwide = LW'(sig1) << sh1;
        rwide = {sig1, {(M+2){1'b0}}} >> sh1;
        mag_c = left1 ? lwide[W:0] : (W+1)'(rwide[2*M+2:M+2]);
        hi_c  = left1 & (|lwide[LW-1:W+1]);
        g_c   = ~left1 & rwide[M+1];
        st_c  = ~left1 & (|rwide[M:0]);
    end
    // Round on the magnitude, then range-check including the increment carry.
    always_comb begin
        inc_c = rnd2 == 2'b00 ? g2 & (s2 | mag2[0]) :
                rnd2 == 2'b01 ? 1'b0 :
                rnd2 == 2'b10 ? sgn2 & (g2 | s2) : ~sgn2 & (g2 | s2);
        sum_c = {1'b0, mag2} + {{(W+1){1'b0}}, inc_c};
        ovf_c = ~zero2 & ~nan2 & (inf2 | hi2 | (sum_c > (sgn2 ? NEG_LIM : POS_LIM)));
        inx_c = ~zero2 & ~nan2 & ~ovf_c & (g2 | s2);
    end
    always_comb begin
        data_c = ovf3 ? (SATURATE != 0 ? (sgn3 ? MIN_V : MAX_V) : ZERO_V)
                      : (sgn3 ? ~mag3 + 1'b1 : mag3);
    end
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            v1 <= 1'b0; sgn1 <= 1'b0; zero1 <= 1'b0; inf1 <= 1'b0; nan1 <= 1'b0; left1 <= 1'b0;
            sh1 <= '0; sig1 <= '0; rnd1 <= '0;
            v2 <= 1'b0; sgn2 <= 1'b0; zero2 <= 1'b0; inf2 <= 1'b0; nan2 <= 1'b0;
            hi2 <= 1'b0; g2 <= 1'b0; s2 <= 1'b0; mag2 <= '0; rnd2 <= '0;
            v3 <= 1'b0; sgn3 <= 1'b0; ovf3 <= 1'b0; inx3 <= 1'b0; nan3 <= 1'b0; mag3 <= '0;
            m_valid <= 1'b0; m_data <= '0; m_overflow <= 1'b0; m_inexact <= 1'b0; m_invalid <= 1'b0;
        end else if (en) begin
            v1    <= s_valid;
            sgn1  <= s_data[M+E];
            zero1 <= exp_f == '0;
            inf1  <= (&exp_f) & (man_f == '0);
            nan1  <= (&exp_f) & (|man_f);
            left1 <= left_c;
            sh1   <= sh_c;
            sig1  <= {1'b1, man_f};
            rnd1  <= s_round;
            v2    <= v1;
            sgn2  <= sgn1;
            zero2 <= zero1;
            inf2  <= inf1;
            nan2  <= nan1;
            hi2   <= hi_c;
            g2    <= g_c;
            s2    <= st_c;
            mag2  <= mag_c;
            rnd2  <= rnd1;
            v3    <= v2;
            sgn3  <= sgn2;
            ovf3  <= ovf_c;
            inx3  <= inx_c;
            nan3  <= nan2;
            mag3  <= (zero2 | nan2) ? ZERO_V : sum_c[W-1:0];
            m_valid    <= v3;
            m_data     <= data_c;
            m_overflow <= ovf3;
            m_inexact  <= inx3;
            m_invalid  <= nan3;
        end
    end
endmodule

// File: tb/tb_float_to_fixed_stream.sv
// tb_float_to_fixed_stream: scoreboard bench for float_to_fixed_stream over three parameter sets
module tb_float_to_fixed_stream;
    typedef struct packed {
        logic [1:0]  d;
        logic [31:0] data;
        logic        ovf;
        logic        inx;
        logic        inv;
        logic        lat;
        logic [31:0] t;
    } exp_t;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic [2:0] sv = '0;
    logic [2:0] sr, mv, mo, mi, mn;
    logic [31:0] md [3];
    logic [31:0] s_data = '0;
    logic [1:0] s_round = '0;
    logic mr = 1'b1;
    int n_assert = 0;
    int n_fail = 0;
    int cyc = 0;
    exp_t pend;
    exp_t q[$];
    logic [31:0] hold [3];
    logic [2:0] stalled = '0;
    logic acc;
    logic bp_en = 1'b0;
    logic [7:0] pat = 8'b1101_1001;
    int pi = 0;
    always #5 clk = ~clk;
    float_to_fixed_stream u_def (
        .clk(clk), .resetn(resetn), .s_valid(sv[0]), .s_ready(sr[0]), .s_data(s_data),
        .s_round(s_round), .m_valid(mv[0]), .m_ready(mr), .m_data(md[0]),
        .m_overflow(mo[0]), .m_inexact(mi[0]), .m_invalid(mn[0]));
    float_to_fixed_stream #(.SATURATE(0)) u_nsat (
        .clk(clk), .resetn(resetn), .s_valid(sv[1]), .s_ready(sr[1]), .s_data(s_data),
        .s_round(s_round), .m_valid(mv[1]), .m_ready(mr), .m_data(md[1]),
        .m_overflow(mo[1]), .m_inexact(mi[1]), .m_invalid(mn[1]));
    float_to_fixed_stream #(.FRAC_BITS(8)) u_frac (
        .clk(clk), .resetn(resetn), .s_valid(sv[2]), .s_ready(sr[2]), .s_data(s_data),
        .s_round(s_round), .m_valid(mv[2]), .m_ready(mr), .m_data(md[2]),
        .m_overflow(mo[2]), .m_inexact(mi[2]), .m_invalid(mn[2]));
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask
    task automatic chk1(input string tag, input logic obs, input logic exp_v);
        chk(tag, {31'b0, obs}, {31'b0, exp_v});
    endtask
    task automatic tick();
        exp_t e;
        logic ok;
        if (bp_en) begin
            mr = pat[pi];
            pi = (pi + 1) % 8;
        end
        #1;
        acc = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk1("s_ready", sr[k], ~(mv[k] & ~mr));
            if (stalled[k]) begin
                chk1("stall_valid", mv[k], 1'b1);
                chk("stall_data", md[k], hold[k]);
            end
            if (sv[k] && sr[k]) begin
                e = pend;
                e.d = 2'(k);
                e.t = 32'(cyc + 1);
                q.push_back(e);
                acc = 1'b1;
            end
            if (mv[k] && mr) begin
                ok = q.size() > 0 && q[0].d == 2'(k);
                n_assert++;
                assert (ok) else begin
                    n_fail++;
                    $error("FAIL unexpected_output dut=%0d observed=%h expected=none", k, md[k]);
                end
                if (ok) begin
                    e = q.pop_front();
                    chk("m_data", md[k], e.data);
                    chk1("m_overflow", mo[k], e.ovf);
                    chk1("m_inexact", mi[k], e.inx);
                    chk1("m_invalid", mn[k], e.inv);
                    if (e.lat) chk("latency", 32'(cyc) - e.t, 32'd3);
                end
            end
            stalled[k] = mv[k] & ~mr;
            hold[k] = md[k];
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask
    task automatic send(input int k, input logic [31:0] d, input logic [1:0] r,
                        input logic [31:0] ed, input logic eo, input logic ei,
                        input logic ev, input logic lat);
        s_data = d;
        s_round = r;
        sv = 3'b001 << k;
        pend = '{d: 2'd0, data: ed, ovf: eo, inx: ei, inv: ev, lat: lat, t: 32'd0};
        for (int i = 0; i < 50; i++) begin
            tick();
            if (acc) break;
        end
        n_assert++;
        assert (acc) else begin
            n_fail++;
            $error("FAIL accept_timeout dut=%0d observed=0 expected=1", k);
        end
        sv = '0;
    endtask
    task automatic drain();
        bp_en = 1'b0;
        mr = 1'b1;
        for (int i = 0; i < 60 && q.size() > 0; i++) tick();
        repeat (4) tick();
        chk("drain_empty", 32'(q.size()), 32'd0);
    endtask
    initial begin
        logic [31:0] ones [8];
        ones = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                 32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};
        #12;
        for (int k = 0; k < 3; k++) begin
            chk1("rst_m_valid", mv[k], 1'b0);
            chk("rst_m_data", md[k], 32'd0);
            chk1("rst_s_ready", sr[k], 1'b1);
            chk("rst_flags", {29'b0, mo[k], mi[k], mn[k]}, 32'd0);
        end
        @(posedge clk);
        #1;
        resetn = 1'b1;
        @(posedge clk);
        cyc++;
        #1;
        // nearest-even basics, back-to-back with latency check
        send(0, 32'h40200000, 2'b00, 32'd2, 1'b0, 1'b1, 1'b0, 1'b1);
        send(0, 32'h40600000, 2'b00, 32'd4, 1'b0, 1'b1, 1'b0, 1'b1);
        send(0, 32'h3F000000, 2'b00, 32'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        send(0, 32'h3F400000, 2'b00, 32'd1, 1'b0, 1'b1, 1'b0, 1'b1);
        send(0, 32'h40E00000, 2'b00, 32'd7, 1'b0, 1'b0, 1'b0, 1'b1);
        // directed rounding modes
        send(0, 32'hC0200000, 2'b10, 32'hFFFFFFFD, 1'b0, 1'b1, 1'b0, 1'b0);
        send(0, 32'hC0200000, 2'b11, 32'hFFFFFFFE, 1'b0, 1'b1, 1'b0, 1'b0);
        send(0, 32'hC0200000, 2'b01, 32'hFFFFFFFE, 1'b0, 1'b1, 1'b0, 1'b0);
        send(0, 32'h40200000, 2'b01, 32'd2, 1'b0, 1'b1, 1'b0, 1'b0);
        send(0, 32'h00800000, 2'b11, 32'd1, 1'b0, 1'b1, 1'b0, 1'b0);
        send(0, 32'h80800000, 2'b10, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0, 1'b0);
        send(0, 32'h80000000, 2'b00, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        // range and special classes
        send(0, 32'h4F32D05E, 2'b00, 32'h7FFFFFFF, 1'b1, 1'b0, 1'b0, 1'b0);
        send(0, 32'hCF000000, 2'b00, 32'h80000000, 1'b0, 1'b0, 1'b0, 1'b0);
        send(0, 32'h4F000000, 2'b00, 32'h7FFFFFFF, 1'b1, 1'b0, 1'b0, 1'b0);
        send(0, 32'h4EFFFFFF, 2'b00, 32'h7FFFFF80, 1'b0, 1'b0, 1'b0, 1'b0);
        send(0, 32'h7F800000, 2'b00, 32'h7FFFFFFF, 1'b1, 1'b0, 1'b0, 1'b0);
        send(0, 32'hFF800000, 2'b00, 32'h80000000, 1'b1, 1'b0, 1'b0, 1'b0);
        send(0, 32'h7FC00000, 2'b00, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        send(1, 32'h4F32D05E, 2'b00, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        send(1, 32'hFF800000, 2'b00, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        // fractional output bits
        send(2, 32'h3FC00000, 2'b00, 32'h00000180, 1'b0, 1'b0, 1'b0, 1'b0);
        send(2, 32'hBB800000, 2'b00, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1'b0);
        send(2, 32'h00000001, 2'b00, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        send(2, 32'h40200000, 2'b00, 32'h00000280, 1'b0, 1'b0, 1'b0, 1'b0);
        drain();
        // backpressure stream
        bp_en = 1'b1;
        pi = 0;
        for (int i = 0; i < 8; i++)
            send(0, ones[i], 2'b00, 32'(i + 1), 1'b0, 1'b0, 1'b0, 1'b0);
        drain();
        // asynchronous reset with samples in flight
        for (int i = 0; i < 4; i++)
            send(0, ones[i], 2'b00, 32'(i + 1), 1'b0, 1'b0, 1'b0, 1'b0);
        chk1("pre_reset_valid", mv[0], 1'b1);
        #2;
        resetn = 1'b0;
        #1;
        chk1("async_rst_valid", mv[0], 1'b0);
        chk("async_rst_data", md[0], 32'd0);
        chk1("async_rst_ready", sr[0], 1'b1);
        q.delete();
        stalled = '0;
        repeat (2) begin
            @(posedge clk);
            cyc++;
        end
        #1;
        resetn = 1'b1;
        send(0, 32'h40A00000, 2'b00, 32'd5, 1'b0, 1'b0, 1'b0, 1'b1);
        drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/float_to_fixed_stream.md
Name: float_to_fixed_stream

Overview:
Pipelined converter from IEEE-style float to signed fixed point, with a valid/ready stream handshake and backpressure. It adds a per-sample rounding mode, a configurable number of fractional output bits, selectable saturation, and status flags. It sits between float arithmetic units and fixed-point consumers such as rasterizer setup and texture addressing. Throughput is one conversion per clock when not stalled.

Parameters:
- MANTISSA_SIZE, 23, stored mantissa bits.
- EXPONENT_SIZE, 8, exponent bits; bias = 2^(EXPONENT_SIZE-1)-1.
- INT_SIZE, 32, output width including sign; must be >= MANTISSA_SIZE+2.
- FRAC_BITS, 0, fractional bits of the output; the result is round(value * 2^FRAC_BITS); range 0..INT_SIZE-2.
- SATURATE, 1, 1 = clamp out-of-range values to min/max; 0 = out-of-range values output 0.

Ports:
- clk  in  1  clock; all logic on its rising edge.
- resetn  in  1  asynchronous, active-low reset.
- s_valid  in  1  input sample valid.
- s_ready  out  1  converter can accept a sample.
- s_data  in  1+EXPONENT_SIZE+MANTISSA_SIZE  float {sign, exponent, mantissa}.
- s_round  in  2  rounding mode: 00 nearest-even, 01 toward zero, 10 floor, 11 ceil.
- m_valid  out  1  output valid.
- m_ready  in  1  downstream accepts output.
- m_data  out  INT_SIZE  signed two's-complement result.
- m_overflow  out  1  value out of range or infinite.
- m_inexact  out  1  nonzero bits were discarded by rounding.
- m_invalid  out  1  input was NaN.

Behaviour:
- Reset (async assert, sync release):
  - All stage valid bits 0; m_valid=0; m_data=0; all flags 0.
  - s_ready=1 while in reset and afterwards.
  - In-flight samples are discarded.
- Pipeline: four register stages sharing one enable, en = ~m_valid | m_ready. s_ready = en (combinational).
  - S1 unpack: sign, e = exp - bias + FRAC_BITS, significand {1, mantissa}, shift direction/amount, class (zero/normal/inf/nan), s_round.
  - S2 shift: left shift, or right shift that produces guard and sticky bits.
  - S3 round: increment and range check.
  - S4 output register: negate, saturate, flags.
- Latency and throughput:
  - A sample accepted (s_valid & s_ready) at edge t is presented on m_data/m_valid from edge t+3.
  - Results leave in input order. Bubbles propagate as valid=0 stages.
- Stall: while m_valid & ~m_ready, every stage holds and m_data/flags are stable. s_data is ignored while s_ready=0.
- Classes:
  - exp==0 (zero or subnormal) is flushed to exact 0; inexact=0. -0 gives 0.
  - exp all-ones with mantissa==0 (Inf) is treated as overflow with the input sign.
  - exp all-ones with mantissa!=0 (NaN) gives m_data=0, m_invalid=1, m_overflow=0, m_inexact=0.
- Rounding on the magnitude. Notation: G = first discarded bit, S = OR of the remaining discarded bits, L = kept LSB.
  - Nearest-even: increment if G & (S | L).
  - Toward zero: never increment.
  - Floor: increment if sign & (G | S).
  - Ceil: increment if ~sign & (G | S).
  - m_inexact = G | S. A left shift (e >= MANTISSA_SIZE) gives G = S = 0.
  - e < 0: the whole significand is discarded. G = (e == -1), S = 1 for e < -1.
- Range is checked after rounding, including the increment carry.
  - Positive: magnitude <= 2^(INT_SIZE-1)-1.
  - Negative: magnitude <= 2^(INT_SIZE-1).
  - Out of range sets m_overflow=1 and m_inexact=0.
  - Out-of-range output: 0x7F..F (positive) or 0x80..0 (negative) if SATURATE=1; 0 if SATURATE=0.
- Negative in-range results are output as ~mag + 1.
- The shift amount is clamped so that no shift exceeds INT_SIZE+1 positions. Large negative e must not wrap.

Test Plan (default params unless stated):
1. Nearest-even, accepted at edge t with m_ready=1, m_valid seen from edge t+3:
   - 2.5 (0x40200000) -> 2, inexact=1.
   - 3.5 (0x40600000) -> 4.
   - 0.5 (0x3F000000) -> 0, inexact=1.
   - 0.75 (0x3F400000) -> 1.
   - 7.0 (0x40E00000) -> 7, inexact=0.
2. Directed modes:
   - -2.5 (0xC0200000): floor -> 0xFFFFFFFD, ceil -> 0xFFFFFFFE, toward zero -> 0xFFFFFFFE.
   - 2.5 toward zero -> 2.
3. Range, SATURATE=1:
   - 3.0e9 (0x4F32D05E) -> 0x7FFFFFFF, overflow=1.
   - -2^31 (0xCF000000) -> 0x80000000, overflow=0.
   - +Inf (0x7F800000) -> 0x7FFFFFFF, overflow=1.
   - -Inf (0xFF800000) -> 0x80000000, overflow=1.
   - NaN (0x7FC00000) -> 0, invalid=1.
   - With SATURATE=0: 3.0e9 -> 0, overflow=1.
4. FRAC_BITS=8:
   - 1.5 (0x3FC00000) -> 0x00000180.
   - -0.00390625 (0xBB800000) -> 0xFFFFFFFF.
   - Subnormal 0x00000001 -> 0, inexact=0.
5. Backpressure:
   - Stream 8 back-to-back samples 1.0..8.0 while m_ready follows pattern 1,0,0,1,1,0,1,1.
   - Required: outputs 1..8 in order, none dropped or duplicated.
   - m_data stays stable while stalled; s_ready=0 exactly when m_valid & ~m_ready.
6. Reset mid-stream: pull resetn low with 3 samples in flight.
   - m_valid=0 and m_data=0 immediately, without waiting for a clock edge.
   - After release, a new sample 5.0 gives 5 with m_valid from t+3, and no stale outputs appear.
